// File: rtl/sdr_rd_capture_if.sv
// sdr_rd_capture_if
//   Groups the read-capture command inputs, the SDRAM DQ pad input and the host-side
//   read result signals into one bundle.
//   master : controller/host side (drives RD_CMD, RD_ABORT, CAS_LAT, BURST_LEN, DQ;
//            receives DATAOUT, DATAVALID, BUSY, RD_ERR, DATALAST)
//   slave  : sdr_rd_capture side (mirror image of master)
// Parameters
//   DSIZE  data width in bits (multiple of 8)
interface sdr_rd_capture_if #(
  parameter int DSIZE = 16
);
  logic             RD_CMD;
  logic             RD_ABORT;
  logic [1:0]       CAS_LAT;
  logic [3:0]       BURST_LEN;
  logic [DSIZE-1:0] DQ;
  logic [DSIZE-1:0] DATAOUT;
  logic             DATAVALID;
  logic             BUSY;
  logic             RD_ERR;
  logic             DATALAST;

  modport master (
    output RD_CMD, RD_ABORT, CAS_LAT, BURST_LEN, DQ,
    input  DATAOUT, DATAVALID, BUSY, RD_ERR, DATALAST
  );

  modport slave (
    input  RD_CMD, RD_ABORT, CAS_LAT, BURST_LEN, DQ,
    output DATAOUT, DATAVALID, BUSY, RD_ERR, DATALAST
  );
endinterface

// File: rtl/sdr_rd_capture.sv
// sdr_rd_capture
//   Read-side SDRAM data capture. A READ command accepted in IDLE latches CAS latency and
//   burst length, waits CAS_LAT + RD_EXTRA_DLY clocks, then samples DQ once per clock for
//   the burst length into a registered DATAOUT with a one-cycle DATAVALID strobe.
// Ports
//   CLK        system clock
//   RESET_N    asynchronous active-low reset
//   bus.RD_CMD     1-cycle READ-issued pulse
//   bus.RD_ABORT   1-cycle burst-terminate pulse
//   bus.CAS_LAT    CAS latency (2 or 3 legal)
//   bus.BURST_LEN  beats per read (1..MAX_BURST)
//   bus.DQ         SDRAM DQ pad input
//   bus.DATAOUT    captured beat (holds last value when DATAVALID=0)
//   bus.DATAVALID  DATAOUT carries a new beat this cycle
//   bus.BUSY       read in flight, RD_CMD must not be pulsed
//   bus.RD_ERR     1-cycle pulse: RD_CMD rejected (busy or illegal config)
//   bus.DATALAST   final-beat marker, only driven when SDR_RD_LAST_EN is defined
// Configuration macro
//   SDR_RD_LAST_EN  enables DATALAST generation; otherwise DATALAST is tied 0.
module sdr_rd_capture #(
  parameter int DSIZE        = 16,
  parameter int MAX_BURST    = 8,
  parameter int RD_EXTRA_DLY = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  sdr_rd_capture_if.slave  bus
);

  localparam int         BW     = $clog2(MAX_BURST) + 1;
  localparam logic [3:0] MAX_BL = 4'(MAX_BURST);
  localparam logic [2:0] EXTRA  = 3'(RD_EXTRA_DLY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT
  } state_t;

  state_t           state;
  logic [2:0]       lat_cnt;
  logic [BW-1:0]    beat_cnt;
  logic [BW-1:0]    beat_last;
  logic [DSIZE-1:0] dataout_q;
  logic             valid_q;
  logic             busy_q;
  logic             err_q;

  logic             cfg_ok;
  logic             final_beat;

  always_comb begin
    cfg_ok = ((bus.CAS_LAT == 2'd2) || (bus.CAS_LAT == 2'd3)) &&
             (bus.BURST_LEN != 4'd0) && (bus.BURST_LEN <= MAX_BL);
    final_beat = (beat_cnt == beat_last) || bus.RD_ABORT;
  end

  // The state returns to IDLE on the edge of the final capture, but busy_q stays high
  // for the DATAVALID cycle that follows; an RD_CMD sampled while busy_q is still set in
  // IDLE is therefore rejected, so a new burst starts only once BUSY has been seen low.
  // lat_cnt is loaded with L-1 so that the first capture lands exactly L edges after E0.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      beat_cnt  <= '0;
      beat_last <= '0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.RD_CMD) begin
            if (busy_q || !cfg_ok) begin
              err_q <= 1'b1;
            end else begin
              state     <= WAIT;
              busy_q    <= 1'b1;
              lat_cnt   <= {1'b0, bus.CAS_LAT} + EXTRA - 3'd1;
              beat_last <= BW'(bus.BURST_LEN - 4'd1);
              beat_cnt  <= '0;
            end
          end
        end

        WAIT: begin
          if (bus.RD_CMD) begin
            err_q <= 1'b1;
          end
          if (bus.RD_ABORT) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (lat_cnt == 3'd1) begin
            state <= CAPT;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        CAPT: begin
          if (bus.RD_CMD) begin
            err_q <= 1'b1;
          end
          dataout_q <= bus.DQ;
          valid_q   <= 1'b1;
          beat_cnt  <= beat_cnt + BW'(1);
          if (final_beat) begin
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SDR_RD_LAST_EN
  logic last_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_q <= 1'b0;
    end else begin
      last_q <= (state == CAPT) && final_beat;
    end
  end

  assign bus.DATALAST = last_q;
`else
  assign bus.DATALAST = 1'b0;
`endif

  assign bus.DATAOUT   = dataout_q;
  assign bus.DATAVALID = valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.RD_ERR    = err_q;

endmodule

// File: tb/tb_sdr_rd_capture.sv
// tb_sdr_rd_capture
//   Directed scenarios followed by a randomized run, each clock checked against an
//   edge-arithmetic reference model: a burst accepted at edge E0 captures DQ at edges
//   E0+L .. E0+L+BL-1 and BUSY falls one edge after the final capture.
module tb_sdr_rd_capture;
  localparam int DSIZE     = 16;
  localparam int MAX_BURST = 8;
  localparam int EXTRA     = 1;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;

  sdr_rd_capture_if #(.DSIZE(DSIZE)) bus ();

  sdr_rd_capture #(
    .DSIZE       (DSIZE),
    .MAX_BURST   (MAX_BURST),
    .RD_EXTRA_DLY(EXTRA)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: one burst record in edge numbers
  bit          have = 1'b0;
  int          acc, cap_first, cap_last, free_e;
  logic [15:0] m_data  = '0;
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_last  = 1'b0;

  bit          ramp      = 1'b0;
  int          ramp_base = 0;
  logic [15:0] got[$];
  bit          got_last[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    int x;
    bit in_burst;
    bit legal;
    int lat;
    x       = cyc;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_last  = 1'b0;
    if (!RESET_N) begin
      have   = 1'b0;
      m_data = '0;
      m_busy = 1'b0;
      return;
    end
    in_burst = have && (x > acc) && (x < free_e);
    if (have && bus.RD_ABORT && (x > acc)) begin
      if (x < cap_first) begin
        cap_last = cap_first - 1;
        free_e   = x + 1;
      end else if (x <= cap_last) begin
        cap_last = x;
        free_e   = x + 2;
      end
    end
    if (have && (x >= cap_first) && (x <= cap_last)) begin
      m_valid = 1'b1;
      m_data  = bus.DQ;
      m_last  = (x == cap_last);
    end
    if (bus.RD_CMD) begin
      legal = ((int'(bus.CAS_LAT) == 2) || (int'(bus.CAS_LAT) == 3)) &&
              (int'(bus.BURST_LEN) >= 1) && (int'(bus.BURST_LEN) <= MAX_BURST);
      if (in_burst || !legal) begin
        m_err = 1'b1;
      end else begin
        have      = 1'b1;
        acc       = x;
        lat       = int'(bus.CAS_LAT) + EXTRA;
        cap_first = x + lat;
        cap_last  = x + lat + int'(bus.BURST_LEN) - 1;
        free_e    = cap_last + 2;
      end
    end
    m_busy = have && (x >= acc) && (x < free_e - 1);
  endtask

  task automatic step();
    logic [15:0] v;
    if (ramp) v = 16'hA000 + 16'(cyc - ramp_base);
    else      v = 16'($urandom);
    bus.DQ = v;
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
    chk("DATAVALID", 32'(bus.DATAVALID), 32'(m_valid));
    chk("BUSY",      32'(bus.BUSY),      32'(m_busy));
    chk("RD_ERR",    32'(bus.RD_ERR),    32'(m_err));
    chk("DATAOUT",   32'(bus.DATAOUT),   32'(m_data));
`ifdef SDR_RD_LAST_EN
    chk("DATALAST",  32'(bus.DATALAST),  32'(m_last));
`else
    chk("DATALAST",  32'(bus.DATALAST),  32'(0));
`endif
    if (bus.DATAVALID === 1'b1) begin
      got.push_back(bus.DATAOUT);
      got_last.push_back(bus.DATALAST);
    end
    bus.RD_CMD   = 1'b0;
    bus.RD_ABORT = 1'b0;
  endtask

  task automatic issue(input int cas, input int bl);
    bus.RD_CMD    = 1'b1;
    bus.CAS_LAT   = 2'(cas);
    bus.BURST_LEN = 4'(bl);
  endtask

  initial begin
    bus.RD_CMD    = 1'b0;
    bus.RD_ABORT  = 1'b0;
    bus.CAS_LAT   = 2'd2;
    bus.BURST_LEN = 4'd4;
    bus.DQ        = '0;
    #1;
    chk("reset_DATAVALID", 32'(bus.DATAVALID), 32'(0));
    chk("reset_BUSY",      32'(bus.BUSY),      32'(0));
    chk("reset_RD_ERR",    32'(bus.RD_ERR),    32'(0));
    chk("reset_DATAOUT",   32'(bus.DATAOUT),   32'(0));
    chk("reset_DATALAST",  32'(bus.DATALAST),  32'(0));
    step();
    step();
    RESET_N = 1'b1;
    step();

    // CAS 2 + EXTRA 1, BL 4, ramp data; second RD_CMD at E2 is rejected
    ramp = 1'b1;
    ramp_base = cyc;
    got.delete(); got_last.delete();
    issue(2, 4);
    step();                       // E0
    bus.CAS_LAT = 2'd3; bus.BURST_LEN = 4'd1;   // must be ignored
    step();                       // E1
    issue(2, 2);
    step();                       // E2
    for (int i = 0; i < 8; i++) step();
    chk("t1_beats", 32'(got.size()), 32'(4));
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("t1_data", 32'(got[i]), 32'(16'hA003 + 16'(i)));
    ramp = 1'b0;

    // CAS 3, BL 1
    got.delete(); got_last.delete();
    issue(3, 1);
    for (int i = 0; i < 8; i++) step();
    chk("t2_beats", 32'(got.size()), 32'(1));
`ifdef SDR_RD_LAST_EN
    if (got_last.size() > 0) chk("t2_last", 32'(got_last[0]), 32'(1));
`endif

    // BL 8 with abort at E0+5
    got.delete(); got_last.delete();
    issue(2, 8);
    step();                       // E0
    for (int i = 0; i < 4; i++) step();   // E1..E4
    bus.RD_ABORT = 1'b1;
    step();                       // E5
    step();                       // E6: BUSY still high for final DATAVALID
    step();                       // E7: BUSY low
    for (int i = 0; i < 8; i++) step();
    chk("t4_beats", 32'(got.size()), 32'(3));
`ifdef SDR_RD_LAST_EN
    if (got_last.size() == 3) chk("t4_last", 32'(got_last[2]), 32'(1));
`endif

    // abort during latency wait
    got.delete(); got_last.delete();
    issue(3, 4);
    step();
    bus.RD_ABORT = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("wait_abort_beats", 32'(got.size()), 32'(0));

    // illegal configurations
    got.delete(); got_last.delete();
    issue(1, 4);
    for (int i = 0; i < 16; i++) step();
    issue(2, 9);
    for (int i = 0; i < 16; i++) step();
    issue(3, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t5_beats", 32'(got.size()), 32'(0));

    // back-to-back: RD_CMD held every cycle, only accepted once BUSY is low
    got.delete(); got_last.delete();
    for (int i = 0; i < 24; i++) begin
      issue(2, 2);
      step();
    end
    for (int i = 0; i < 8; i++) step();

    // reset in the middle of a BL 8 burst
    got.delete(); got_last.delete();
    issue(2, 8);
    for (int i = 0; i < 5; i++) step();   // E0..E4
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t6_DATAVALID", 32'(bus.DATAVALID), 32'(0));
    chk("t6_BUSY",      32'(bus.BUSY),      32'(0));
    chk("t6_DATAOUT",   32'(bus.DATAOUT),   32'(0));
    have = 1'b0; m_data = '0;
    step();
    step();
    RESET_N = 1'b1;
    got.delete(); got_last.delete();
    for (int i = 0; i < 12; i++) step();
    chk("t6_no_beats", 32'(got.size()), 32'(0));
    issue(3, 5);
    for (int i = 0; i < 12; i++) step();
    chk("t6_fresh_beats", 32'(got.size()), 32'(5));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.RD_CMD = 1'b1;
        if ($urandom_range(0, 7) == 0) bus.CAS_LAT = 2'($urandom_range(0, 1));
        else                           bus.CAS_LAT = 2'($urandom_range(2, 3));
        if ($urandom_range(0, 7) == 0) bus.BURST_LEN = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
        else                           bus.BURST_LEN = 4'($urandom_range(1, MAX_BURST));
      end else if ($urandom_range(0, 3) == 0) begin
        bus.CAS_LAT   = 2'($urandom);
        bus.BURST_LEN = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bus.RD_ABORT = 1'b1;
      step();
    end
    for (int i = 0; i < 12; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
